// File: rtl/conv_out_writer_pkg.sv
// Shared definitions for the convolution output writer: FSM encoding and
// elaboration-time sizing helpers.
package conv_out_writer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      FLUSH = 2'b10,
      DONE  = 2'b11
   } state_t;

   // Width of a counter able to index n items; never less than one bit.
   function automatic int clog2_safe(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int words_per_frame(input int out_size, input int ppw);
      return (out_size * out_size + ppw - 1) / ppw;
   endfunction

endpackage

// File: rtl/conv_out_writer_if.sv
// Pixel input strobe and external-memory write port of the output writer.
// Write handshake: a word transfers on a rising edge where mem_we && mem_ready;
// while mem_we=1 and mem_ready=0, mem_addr/mem_wdata hold. pix_valid has no ready.
interface conv_out_writer_if #(
   parameter int EADDR = 32,
   parameter int PIXEL = 8,
   parameter int PPW   = 4
);
   logic                   pix_valid;
   logic [PIXEL-1:0]       pix_in;
   logic [EADDR-1:0]       mem_addr;
   logic [PPW*PIXEL-1:0]   mem_wdata;
   logic                   mem_we;
   logic                   mem_ready;

   modport master (
      input  pix_valid, pix_in, mem_ready,
      output mem_addr, mem_wdata, mem_we
   );

   modport slave (
      output pix_valid, pix_in, mem_ready,
      input  mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/conv_out_writer_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; dout is the head word, or 0 when empty.
module sync_fifo_fwft
   import conv_out_writer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int AW = clog2_safe(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp, rp;
   logic [CW-1:0]    cnt;
   logic             wr_en, rd_en;

   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));
   // A push into a full FIFO is accepted only when the head leaves on the same edge.
   assign wr_en = push & (~full | pop);
   assign rd_en = pop & ~empty;
   assign dout  = empty ? '0 : mem[rp];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wp] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (wr_en) wp <= wp + 1'b1;
         if (rd_en) rp <= rp + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// File: rtl/conv_out_writer.sv
// Output stage after the 5x5 convolution engine: captures pixels, tracks their
// position, packs them little-endian into words and writes them out via a FIFO.
module conv_out_writer
   import conv_out_writer_pkg::*;
#(
   parameter int          EADDR      = 32,
   parameter int          PIXEL      = 8,
   parameter int          PPW        = 4,
   parameter int          OUT_SIZE   = 508,
   parameter logic [63:0] BASE_ADDR  = 64'd0,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   conv_out_writer_if.master bus,
   output logic [8:0]        row_idx,
   output logic [8:0]        col_idx,
   output logic              overflow,
   output logic              done,
   output state_t            fsm_state
);
   localparam int              W         = PPW * PIXEL;
   localparam int              LANEW     = clog2_safe(PPW);
   localparam logic [8:0]      LAST_IDX  = 9'(OUT_SIZE - 1);
   localparam logic [EADDR-1:0] ADDR_STEP = EADDR'(W / 8);

   state_t           state, state_n;
   logic [LANEW-1:0] lane;
   logic [W-1:0]     pack, word_full, fifo_din, fifo_dout;
   logic [8:0]       next_row, next_col;
   logic [EADDR-1:0] mem_addr;
   logic             capture, lane_top, last_pix, flush_push, push, pop, clear;
   logic             fifo_full, fifo_empty;

   assign lane_top = (lane == LANEW'(PPW - 1));
   assign last_pix = (next_row == LAST_IDX) && (next_col == LAST_IDX);
   assign pop      = bus.mem_we & bus.mem_ready;
   assign push     = (capture & lane_top) | flush_push;
   assign fifo_din = flush_push ? pack : word_full;

   // Word as it would look with the incoming pixel dropped into the current lane.
   always_comb begin
      word_full = pack;
      word_full[lane*PIXEL +: PIXEL] = bus.pix_in;
   end

   always_comb begin
      state_n    = state;
      capture    = 1'b0;
      flush_push = 1'b0;
      clear      = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               clear   = 1'b1;
               state_n = RUN;
            end
         end
         RUN: begin
            if (bus.pix_valid) begin
               capture = 1'b1;
               if (last_pix) state_n = FLUSH;
            end
         end
         FLUSH: begin
            if (lane != '0) flush_push = 1'b1;
            else if (fifo_empty) state_n = DONE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane     <= '0;
         pack     <= '0;
         next_row <= '0;
         next_col <= '0;
         row_idx  <= '0;
         col_idx  <= '0;
         overflow <= 1'b0;
         mem_addr <= '0;
      end else if (clear) begin
         lane     <= '0;
         pack     <= '0;
         next_row <= '0;
         next_col <= '0;
         row_idx  <= '0;
         col_idx  <= '0;
         overflow <= 1'b0;
         mem_addr <= EADDR'(BASE_ADDR);
      end else begin
         if (capture) begin
            row_idx <= next_row;
            col_idx <= next_col;
            if (next_col == LAST_IDX) begin
               next_col <= '0;
               next_row <= next_row + 9'd1;
            end else begin
               next_col <= next_col + 9'd1;
            end
            // Pack is zeroed after each push so a partial word is already zero-padded.
            if (lane_top) begin
               lane <= '0;
               pack <= '0;
            end else begin
               lane <= lane + 1'b1;
               pack <= word_full;
            end
         end
         if (flush_push) begin
            lane <= '0;
            pack <= '0;
         end
         if (push && fifo_full && !pop) overflow <= 1'b1;
         if (pop) mem_addr <= mem_addr + ADDR_STEP;
      end
   end

   sync_fifo_fwft #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (fifo_din),
      .pop   (pop),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign bus.mem_we    = ~fifo_empty;
   assign bus.mem_wdata = fifo_dout;
   assign bus.mem_addr  = mem_addr;
   assign done          = (state == DONE);
   assign fsm_state     = state;
endmodule

// File: tb/tb_conv_out_writer.sv
// Bench for conv_out_writer: three instances (4x4, 3x3, 4x4 with a 2-deep FIFO)
// checked against a frame-level packing model through per-instance expected queues.
module tb_conv_out_writer;
   import conv_out_writer_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic [2:0]      start_d, pv_d, rdy_d;
   logic [2:0][7:0] pi_d;
   logic [2:0][8:0] row_s, col_s;
   logic [2:0]      ovf_s, done_s, we_s;
   logic [2:0][1:0] st_s;
   logic [2:0][31:0] addr_s, data_s;

   logic [63:0] exp_q0[$], exp_q1[$], exp_q2[$];
   logic [7:0]  pix_vals[$];
   logic [63:0] mon_h;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      conv_out_writer_if #(.EADDR(32), .PIXEL(8), .PPW(4)) bus ();
      state_t st;
      assign bus.pix_valid = pv_d[g];
      assign bus.pix_in    = pi_d[g];
      assign bus.mem_ready = rdy_d[g];
      assign we_s[g]       = bus.mem_we;
      assign addr_s[g]     = bus.mem_addr;
      assign data_s[g]     = bus.mem_wdata;
      assign st_s[g]       = st;
      conv_out_writer #(
         .EADDR(32), .PIXEL(8), .PPW(4),
         .OUT_SIZE((g == 1) ? 3 : 4),
         .BASE_ADDR(64'd0),
         .FIFO_DEPTH((g == 2) ? 2 : 16)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .start     (start_d[g]),
         .bus       (bus),
         .row_idx   (row_s[g]),
         .col_idx   (col_s[g]),
         .overflow  (ovf_s[g]),
         .done      (done_s[g]),
         .fsm_state (st)
      );
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", nm, act, req);
      end
   endtask

   function automatic string nm(input string s, input int i);
      return $sformatf("dut%0d_%s", i, s);
   endfunction

   function automatic void exp_push(input int i, input logic [63:0] v);
      case (i)
         0:       exp_q0.push_back(v);
         1:       exp_q1.push_back(v);
         default: exp_q2.push_back(v);
      endcase
   endfunction

   function automatic int exp_size(input int i);
      case (i)
         0:       return exp_q0.size();
         1:       return exp_q1.size();
         default: return exp_q2.size();
      endcase
   endfunction

   function automatic logic [63:0] exp_head(input int i);
      case (i)
         0:       return exp_q0[0];
         1:       return exp_q1[0];
         default: return exp_q2[0];
      endcase
   endfunction

   function automatic void exp_pop(input int i);
      case (i)
         0:       void'(exp_q0.pop_front());
         1:       void'(exp_q1.pop_front());
         default: void'(exp_q2.pop_front());
      endcase
   endfunction

   // mode 0: always ready, 1: random 70%, 2: stalled until late
   function automatic void set_ready(input int i, input int mode, input bit late);
      rdy_d[i] = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(99) < 70) : late;
   endfunction

   // Monitor: every presented write word must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         for (int i = 0; i < 3; i++) begin
            if (we_s[i]) begin
               if (exp_size(i) == 0) begin
                  total++;
                  bad++;
                  $display("FAIL dut%0d_unexpected_write: got addr=%0h data=%0h required no write",
                           i, addr_s[i], data_s[i]);
               end else begin
                  mon_h = exp_head(i);
                  check(nm("wr_addr", i), 64'(addr_s[i]), 64'(mon_h[63:32]));
                  check(nm("wr_data", i), 64'(data_s[i]), 64'(mon_h[31:0]));
                  if (rdy_d[i]) exp_pop(i);
               end
            end
         end
      end
   end

   task automatic check_idle_outputs(input int i);
      check(nm("we_zero", i),    64'(we_s[i]),   64'(0));
      check(nm("addr_zero", i),  64'(addr_s[i]), 64'(0));
      check(nm("wdata_zero", i), 64'(data_s[i]), 64'(0));
      check(nm("row_zero", i),   64'(row_s[i]),  64'(0));
      check(nm("col_zero", i),   64'(col_s[i]),  64'(0));
      check(nm("ovf_zero", i),   64'(ovf_s[i]),  64'(0));
      check(nm("done_zero", i),  64'(done_s[i]), 64'(0));
      check(nm("state_idle", i), 64'(st_s[i]),   64'(IDLE));
   endtask

   task automatic fill_seq(input int n, input int first);
      pix_vals.delete();
      for (int k = 0; k < n; k++) pix_vals.push_back(8'(first + k));
   endtask

   task automatic fill_rand(input int n);
      pix_vals.delete();
      for (int k = 0; k < n; k++) pix_vals.push_back(8'($urandom_range(255)));
   endtask

   task automatic run_frame(input int i, input int side, input int gap_pct, input int rmode,
                            input int max_words, input int abort_after, input bit mid_start);
      int n  = side * side;
      int nw = words_per_frame(side, 4);
      int c;
      int w;
      logic [31:0] wd;
      @(posedge clk); #1;
      start_d[i] = 1'b1;
      set_ready(i, rmode, 1'b0);
      @(posedge clk); #1;
      start_d[i] = 1'b0;
      check(nm("state_run", i), 64'(st_s[i]), 64'(RUN));
      check(nm("ovf_cleared", i), 64'(ovf_s[i]), 64'(0));
      check(nm("done_cleared", i), 64'(done_s[i]), 64'(0));
      for (int k = 0; k < n; k++) begin
         while ($urandom_range(99) < gap_pct) begin
            pv_d[i] = 1'b0;
            set_ready(i, rmode, 1'b0);
            @(posedge clk); #1;
         end
         pv_d[i]    = 1'b1;
         pi_d[i]    = pix_vals[k];
         start_d[i] = mid_start && (k == n / 2);
         set_ready(i, rmode, 1'b0);
         @(posedge clk); #1;
         start_d[i] = 1'b0;
         check(nm("row", i), 64'(row_s[i]), 64'(k / side));
         check(nm("col", i), 64'(col_s[i]), 64'(k % side));
         if (k == 2) check(nm("we_before_first_word", i), 64'(we_s[i]), 64'(0));
         if (k == 3) check(nm("we_after_first_word", i), 64'(we_s[i]), 64'(1));
         if ((k % 4 == 3) || (k == n - 1)) begin
            w = k / 4;
            if (w < max_words) begin
               wd = '0;
               for (int l = 0; l < 4; l++)
                  if (4 * w + l < n) wd[8*l +: 8] = pix_vals[4*w + l];
               exp_push(i, {32'(4 * w), wd});
            end
         end
         if (k + 1 == abort_after) begin
            pv_d[i] = 1'b0;
            return;
         end
      end
      pv_d[i] = 1'b0;
      c = 0;
      while (!done_s[i] && c < 300) begin
         set_ready(i, rmode, c >= 20);
         @(posedge clk); #1;
         c++;
      end
      check(nm("done", i), 64'(done_s[i]), 64'(1));
      check(nm("state_done", i), 64'(st_s[i]), 64'(DONE));
      check(nm("overflow", i), 64'(ovf_s[i]), 64'(max_words < nw));
      check(nm("all_words_written", i), 64'(exp_size(i)), 64'(0));
      // Pixels after the frame must be ignored.
      repeat (3) begin
         pv_d[i] = 1'b1;
         pi_d[i] = 8'($urandom_range(255));
         @(posedge clk); #1;
      end
      pv_d[i] = 1'b0;
      check(nm("row_hold", i), 64'(row_s[i]), 64'(side - 1));
      check(nm("col_hold", i), 64'(col_s[i]), 64'(side - 1));
      check(nm("done_hold", i), 64'(done_s[i]), 64'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      start_d = '0;
      pv_d    = '0;
      rdy_d   = '0;
      pi_d    = '0;
      #12;
      for (int i = 0; i < 3; i++) check_idle_outputs(i);
      @(posedge clk); #1;
      rst   = 1'b0;
      rdy_d = '1;

      // basic 4x4 frame, back-to-back pixels
      fill_seq(16, 8'h00);
      run_frame(0, 4, 0, 0, 99, 0, 1'b0);
      // 3x3 frame with a padded partial word
      fill_seq(9, 8'h11);
      run_frame(1, 3, 0, 0, 99, 0, 1'b0);
      // long write stall
      fill_rand(16);
      run_frame(0, 4, 0, 2, 99, 0, 1'b0);
      // overflow with a 2-deep FIFO
      fill_seq(16, 8'h40);
      run_frame(2, 4, 0, 2, 2, 0, 1'b0);
      fill_rand(16);
      run_frame(2, 4, 0, 0, 99, 0, 1'b0);

      // asynchronous reset mid-frame, then a clean frame
      fill_seq(16, 8'h00);
      run_frame(0, 4, 0, 2, 99, 6, 1'b0);
      rst = 1'b1;
      #1;
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
      check_idle_outputs(0);
      @(posedge clk); #1;
      rst   = 1'b0;
      rdy_d = '1;
      fill_seq(16, 8'h00);
      run_frame(0, 4, 0, 0, 99, 0, 1'b0);

      // randomized frames with gaps, random ready and an ignored mid-frame start
      for (int r = 0; r < 4; r++) begin
         fill_rand(16);
         run_frame(0, 4, 30, 1, 99, 0, r[0]);
         fill_rand(9);
         run_frame(1, 3, 30, 1, 99, 0, ~r[0]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
